// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered ID->EX immediate extension stage; IMM_EXT_SKID_EN selects the 2-entry skid buffer
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int EXT_W = OUT_W - IN_W;

  // The branch mode shifts the sign-extended value left by two, so two spare bits are needed.
  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_ext_pipe: OUT_W must be >= IN_W+2");
  end

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_ext;

  // Extend the incoming immediate now so held entries are stored in final form.
  always_comb begin
    w_sign = {{EXT_W{imm_in[IN_W-1]}}, imm_in};
    w_ext  = w_sign;
    case (mode)
      2'b00:   w_ext = w_sign;
      2'b01:   w_ext = {{EXT_W{1'b0}}, imm_in};
      2'b10:   w_ext = {imm_in, {EXT_W{1'b0}}};
      default: w_ext = {w_sign[OUT_W-3:0], 2'b00};
    endcase
  end

`ifdef IMM_EXT_SKID_EN

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_cnt;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_head_imm;
  logic [TAG_W-1:0] r_head_tag;
  logic [OUT_W-1:0] r_tail_imm;
  logic [TAG_W-1:0] r_tail_tag;
  logic             w_accept;
  logic             w_retire;
  logic [1:0]       w_cnt_nxt;

  assign w_accept  = in_valid & r_in_ready;
  assign w_retire  = r_out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign imm_out   = r_head_imm;
  assign tag_out   = r_head_tag;

  // Occupancy transition for the handshake events of this cycle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case (r_cnt)
      S_EMPTY: if (w_accept) w_cnt_nxt = S_ONE;
      S_ONE: begin
        if (w_accept && !w_retire)      w_cnt_nxt = S_TWO;
        else if (!w_accept && w_retire) w_cnt_nxt = S_EMPTY;
      end
      S_TWO:   if (w_retire) w_cnt_nxt = S_ONE;
      default: w_cnt_nxt = S_EMPTY;
    endcase
  end

  // State, flags and the two entry registers; head is always the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_head_imm  <= '0;
      r_head_tag  <= '0;
      r_tail_imm  <= '0;
      r_tail_tag  <= '0;
    end else if (flush) begin
      r_cnt       <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_cnt_nxt != S_EMPTY);
      r_in_ready  <= (w_cnt_nxt != S_TWO);
      case (r_cnt)
        S_EMPTY: begin
          if (w_accept) begin
            r_head_imm <= w_ext;
            r_head_tag <= tag_in;
          end
        end
        S_ONE: begin
          if (w_accept && w_retire) begin
            r_head_imm <= w_ext;
            r_head_tag <= tag_in;
          end else if (w_accept) begin
            r_tail_imm <= w_ext;
            r_tail_tag <= tag_in;
          end
        end
        S_TWO: begin
          if (w_retire) begin
            r_head_imm <= r_tail_imm;
            r_head_tag <= r_tail_tag;
          end
        end
        default: ;
      endcase
    end
  end

`else

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_ONE   = 1'b1;

  logic [0:0]       r_cnt;
  logic [OUT_W-1:0] r_head_imm;
  logic [TAG_W-1:0] r_head_tag;
  logic             w_accept;
  logic             w_retire;

  assign out_valid = (r_cnt == S_ONE);
  assign in_ready  = !out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_retire  = out_valid & out_ready;
  assign imm_out   = r_head_imm;
  assign tag_out   = r_head_tag;

  // Single holding register; an accept in the same cycle as a retire replaces the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= S_EMPTY;
      r_head_imm <= '0;
      r_head_tag <= '0;
    end else if (flush) begin
      r_cnt <= S_EMPTY;
    end else if (w_accept) begin
      r_cnt      <= S_ONE;
      r_head_imm <= w_ext;
      r_head_tag <= tag_in;
    end else if (w_retire) begin
      r_cnt <= S_EMPTY;
    end
  end

`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - scoreboard bench for imm_ext_pipe
module tb_imm_ext_pipe;

`ifdef IMM_EXT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  tag;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] imm_in = '0;
  logic [1:0]  mode = '0;
  logic [4:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] imm_out;
  logic [4:0]  tag_out;

  int     n_checks = 0;
  int     n_pass = 0;
  entry_t sb[$];
  bit     acc;
  bit     ret;
  int     n_acc;
  int     n_ret;
  logic [31:0] held_imm;
  logic [4:0]  held_tag;
  bit     got;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_in(imm_in), .mode(mode), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [15:0] imm, logic [1:0] m);
    int v;
    v = $signed(imm);
    case (m)
      2'd0:    return 32'(v);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'(v * 4);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // One clock: check outputs against the scoreboard, apply the handshakes, cross the edge.
  task automatic step();
    entry_t e;
    #1;
    acc = 1'b0;
    ret = 1'b0;
    if (!rst) begin
      check("out_valid_occ", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready_occ", 32'(in_ready),
            SKID ? 32'(sb.size() < 2) : 32'((sb.size() == 0) || out_ready));
      if (out_valid && sb.size() != 0) begin
        check("head_imm", imm_out, sb[0].imm);
        check("head_tag", 32'(tag_out), 32'(sb[0].tag));
      end
    end
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        ret = 1'b1;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{imm: model(imm_in, mode), tag: tag_in});
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Hold one input until accepted or the cycle budget runs out.
  task automatic send(input logic [15:0] imm, input logic [1:0] m, input logic [4:0] t,
                      input int max, output bit accepted);
    in_valid = 1'b1;
    imm_in   = imm;
    mode     = m;
    tag_in   = t;
    accepted = 1'b0;
    for (int i = 0; i < max && !accepted; i++) begin
      step();
      accepted = acc;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [15:0] t2_imm [4] = '{16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
  logic [1:0]  t2_mode[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
  logic [31:0] t2_exp [4] = '{32'h0000_8001, 32'h1234_0000, 32'hFFFF_FFFC, 32'h0001_FFFC};

  initial begin
    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_imm_out", imm_out, 32'd0);
    check("rst_tag_out", 32'(tag_out), 32'd0);

    // 1: SIGN, one-cycle latency
    out_ready = 1'b1;
    send(16'h8001, 2'd0, 5'd1, 1, got);
    check("t1_accept", 32'(got), 32'd1);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_imm", imm_out, 32'hFFFF_8001);
    step();

    // 2: remaining modes against fixed constants
    for (int k = 0; k < 4; k++) begin
      send(t2_imm[k], t2_mode[k], 5'(k + 2), 1, got);
      check("t2_out_valid", 32'(out_valid), 32'd1);
      check("t2_imm", imm_out, t2_exp[k]);
    end
    step();

    // 3: back-pressure then in-order release
    out_ready = 1'b0;
    send(16'h0011, 2'd1, 5'd1, 4, got);
    check("t3_tag1_acc", 32'(got), 32'd1);
    send(16'h0022, 2'd1, 5'd2, 4, got);
    check("t3_tag2_acc", 32'(got), 32'(SKID));
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    check("t3_head_tag", 32'(tag_out), 32'd1);
    if (!SKID) begin
      out_ready = 1'b1;
      send(16'h0022, 2'd1, 5'd2, 10, got);
      check("t3_tag2_late", 32'(got), 32'd1);
      out_ready = 1'b0;
    end
    in_valid = 1'b1; imm_in = 16'h0033; mode = 2'd1; tag_in = 5'd3;
    step();
    step();
    out_ready = 1'b1;
    send(16'h0033, 2'd1, 5'd3, 10, got);
    check("t3_tag3_acc", 32'(got), 32'd1);
    drain();

    // 4: flush while full, with a competing input
    out_ready = 1'b0;
    send(16'h0A0A, 2'd0, 5'd10, 4, got);
    send(16'h0B0B, 2'd0, 5'd11, 2, got);
    held_imm = imm_out;
    held_tag = tag_out;
    flush = 1'b1;
    in_valid = 1'b1; imm_in = 16'h5555; mode = 2'd1; tag_in = 5'd31;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_imm_hold", imm_out, held_imm);
    check("t4_tag_hold", 32'(tag_out), 32'(held_tag));
    step();
    step();

    // 5: reset mid-transfer
    out_ready = 1'b0;
    send(16'h4321, 2'd2, 5'd7, 2, got);
    check("t5_held", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_imm_out", imm_out, 32'd0);
    check("t5_tag_out", 32'(tag_out), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);

    // 6: streaming throughput with random immediates and modes
    out_ready = 1'b1;
    n_acc = 0;
    n_ret = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      imm_in = 16'($urandom);
      mode = 2'($urandom_range(0, 3));
      tag_in = 5'($urandom);
      step();
      n_acc += int'(acc);
      n_ret += int'(ret);
    end
    in_valid = 1'b0;
    check("t6_accepts", 32'(n_acc), 32'd100);
    check("t6_retires", 32'(n_ret), 32'd99);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
